// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared ALU op codes and datapath width
package alu_share_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [SEL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - combinational 32-bit ALU with zero flag
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] out,
  output logic              zf
);

  always_comb begin
    out = '0;
    case (sel)
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_ADD: out = a + b;
      ALU_SUB: out = a - b;
      ALU_SLT: out = DATA_W'(a < b);
      ALU_NOR: out = ~(a | b);
      default: out = '0;
    endcase
    zf = (out == '0);
  end

endmodule

// File: rtl/alu_share_arbiter_rr.sv
// rtl/alu_share_arbiter_rr.sv - round-robin grant search starting just above ptr
module alu_share_arbiter_rr #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = ID_W'((int'(ptr) + off) % NREQ);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU among NREQ requesters
// Round-robin pick into an operand stage, ALU result lands in the response stage.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*SEL_W-1:0]  req_sel,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [DATA_W-1:0]      resp_out,
  output logic                   resp_zf
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              s1_v_q, s1_v_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic [SEL_W-1:0]  s1_sel_q, s1_sel_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              s2_v_q, s2_v_d;
  logic [DATA_W-1:0] resp_out_q, resp_out_d;
  logic              resp_zf_q, resp_zf_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_valid;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zf;
  logic              s2_load, s1_free, accept;

  alu_share_arbiter_rr #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  alu_share_arbiter_alu u_alu (
    .a   (s1_a_q),
    .b   (s1_b_q),
    .sel (s1_sel_q),
    .out (alu_out),
    .zf  (alu_zf)
  );

  always_comb begin
    // Operand stage frees up in the same cycle it hands its op forward.
    s2_load   = s1_v_q & (~s2_v_q | resp_ready);
    s1_free   = ~s1_v_q | s2_load;
    accept    = gnt_valid & s1_free & ~rst;
    req_ready = accept ? gnt : '0;

    ptr_d      = ptr_q;
    s1_v_d     = s1_v_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    s1_id_d    = s1_id_q;
    s2_v_d     = s2_v_q;
    resp_out_d = resp_out_q;
    resp_zf_d  = resp_zf_q;
    resp_id_d  = resp_id_q;

    if (s2_load) begin
      s2_v_d     = 1'b1;
      resp_out_d = alu_out;
      resp_zf_d  = alu_zf;
      resp_id_d  = s1_id_q;
    end else if (resp_ready) begin
      s2_v_d = 1'b0;
    end

    if (accept) begin
      s1_v_d   = 1'b1;
      s1_a_d   = req_a[DATA_W*gnt_idx +: DATA_W];
      s1_b_d   = req_b[DATA_W*gnt_idx +: DATA_W];
      s1_sel_d = req_sel[SEL_W*gnt_idx +: SEL_W];
      s1_id_d  = gnt_idx;
      ptr_d    = gnt_idx;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= ID_W'(NREQ - 1);
      s1_v_q     <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sel_q   <= '0;
      s1_id_q    <= '0;
      s2_v_q     <= 1'b0;
      resp_out_q <= '0;
      resp_zf_q  <= 1'b0;
      resp_id_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_v_q     <= s1_v_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sel_q   <= s1_sel_d;
      s1_id_q    <= s1_id_d;
      s2_v_q     <= s2_v_d;
      resp_out_q <= resp_out_d;
      resp_zf_q  <= resp_zf_d;
      resp_id_q  <= resp_id_d;
    end
  end

  assign resp_valid = s2_v_q;
  assign resp_out   = resp_out_q;
  assign resp_zf    = resp_zf_q;
  assign resp_id    = resp_id_q;

endmodule
